// File: rtl/aes_inv_mixcol_iter.sv
// Iterative AES InvMixColumns engine: captures a 128-bit state, rewrites it in
// place COLS_PER_CYCLE columns per clock, then holds the result until accepted.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// BUSY  | transforming columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 each clock
// DONE  | result held on out_state with out_valid high
module aes_inv_mixcol_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_inv_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [127:0]  work_q;
    logic [127:0]  work_upd;
    logic [1:0]    col_cnt_q;
    logic [31:0]   col_out [COLS_PER_CYCLE];
    logic [1:0]    col_sel [COLS_PER_CYCLE];
    logic          capture;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 9/b/d/e multiples built from the x2, x4, x8 chain of each byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Column c lives at bit offset (3-c)*32, i.e. {~c, 5'b0}
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        logic [1:0]  idx;
        logic [31:0] col_in;
        assign idx        = col_cnt_q + 2'(j);
        assign col_in     = work_q[{~idx, 5'b0} +: 32];
        assign col_out[j] = inv_mix_col(col_in);
        assign col_sel[j] = idx;
    end

    always_comb begin
        work_upd = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_upd[{~col_sel[j], 5'b0} +: 32] = col_out[j];
        end
    end

    assign capture = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            col_cnt_q <= '0;
        end else if (capture) begin
            work_q    <= in_state;
            col_cnt_q <= '0;
        end else if (state_q == S_BUSY) begin
            work_q    <= work_upd;
            col_cnt_q <= col_cnt_q + CNT_STEP;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid) state_d = S_BUSY;
            S_BUSY: if (col_cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = in_valid ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready in DONE lets a new state enter on the same edge the result leaves
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign out_state = work_q;

endmodule
